// File: rtl/mod_n_wrap_stage.sv
// ---------------------------------------------------------------------------
// mod_n_wrap_stage
//
// Downstream digit of a two-digit counter. It samples the count of an
// upstream mod-N counter every clock and detects each wrap (N-1 -> 0).
// It counts those wraps modulo M. A wrap raises a one-cycle wrap pulse.
// When this stage's own digit rolls over, a one-cycle carry is raised too.
//
// Optional feature macro: MOD_N_WRAP_CHECK_EN
//   When defined, a sticky err flag is set when an upstream sample is out
//   of range or is not a legal successor of the previous sample.
//   When undefined, err is tied to 0 and no check logic exists.
//
// Ports:
//   clk        in   1   rising-edge clock, shared with the upstream counter
//   clr        in   1   asynchronous active-high reset
//   en         in   1   sample enable; 0 holds all state
//   q_in       in   CW  upstream count value
//   wrap_cnt   out  MW  number of wraps seen, modulo M
//   wrap_pulse out  1   one-cycle pulse per detected wrap
//   carry      out  1   one-cycle pulse when wrap_cnt rolls M-1 -> 0
//   err        out  1   sticky illegal-sequence flag (0 without the macro)
// ---------------------------------------------------------------------------
module mod_n_wrap_stage #(
   parameter int N  = 3,
   parameter int CW = 2,
   parameter int M  = 4,
   parameter int MW = 2
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] q_in,
   output logic [MW-1:0] wrap_cnt,
   output logic          wrap_pulse,
   output logic          carry,
   output logic          err
);

   typedef enum logic {INIT, TRACK} state_t;

   localparam logic [CW-1:0] Q_LAST   = CW'(N - 1);
   localparam logic [MW-1:0] CNT_LAST = MW'(M - 1);

   state_t        state;
   logic [CW-1:0] prev_q;
   logic          is_wrap;

   // A wrap is the upstream count going from its last legal value to 0.
   // An upstream clear from N-1 looks identical and is counted as a wrap.
   assign is_wrap = (prev_q == Q_LAST) && (q_in == '0);

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values of the others, matching real flops.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= INIT;
         prev_q     <= '0;
         wrap_cnt   <= '0;
         wrap_pulse <= 1'b0;
         carry      <= 1'b0;
      end else begin
         // Pulses default low so each lasts exactly one cycle.
         wrap_pulse <= 1'b0;
         carry      <= 1'b0;
         if (en) begin
            prev_q <= q_in;
            case (state)
               // First sample after reset only arms prev_q.
               INIT: state <= TRACK;
               TRACK: begin
                  if (is_wrap) begin
                     wrap_pulse <= 1'b1;
                     if (wrap_cnt == CNT_LAST) begin
                        wrap_cnt <= '0;
                        carry    <= 1'b1;
                     end else begin
                        wrap_cnt <= wrap_cnt + MW'(1);
                     end
                  end
               end
               default: state <= INIT;
            endcase
         end
      end
   end

`ifdef MOD_N_WRAP_CHECK_EN
   logic out_of_range;
   logic legal_step;
   logic seq_bad;

   // NOTE: every signal written here gets a value on every path, so no
   // latch is inferred.
   always_comb begin
      // Zero-extend by one bit so N == 2**CW still compares correctly.
      out_of_range = ({1'b0, q_in} >= (CW + 1)'(N));
      legal_step   = (q_in == prev_q) || (q_in == '0) ||
                     ((prev_q < Q_LAST) && (q_in == prev_q + CW'(1)));
      seq_bad      = out_of_range || !legal_step;
   end

   // Sticky until clr; illegal samples are still captured into prev_q.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         err <= 1'b0;
      end else if (en && (state == TRACK) && seq_bad) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_n_wrap_stage.sv
// ---------------------------------------------------------------------------
// tb_mod_n_wrap_stage
//
// Directed testbench for mod_n_wrap_stage with N=3, CW=2, M=4, MW=2.
// Each scenario task drives a short vector table and compares the outputs
// against hand-computed expectations. Expected err values depend on whether
// MOD_N_WRAP_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_mod_n_wrap_stage;

   logic       clk = 1'b0;
   logic       clr;
   logic       en;
   logic [1:0] q_in;
   logic [1:0] wrap_cnt;
   logic       wrap_pulse;
   logic       carry;
   logic       err;

   int total = 0;
   int bad   = 0;

`ifdef MOD_N_WRAP_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   mod_n_wrap_stage #(.N(3), .CW(2), .M(4), .MW(2)) dut (
      .clk        (clk),
      .clr        (clr),
      .en         (en),
      .q_in       (q_in),
      .wrap_cnt   (wrap_cnt),
      .wrap_pulse (wrap_pulse),
      .carry      (carry),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Apply one sample and settle 1 time unit after the edge.
   task automatic drive(input logic e, input logic [1:0] q);
      en   = e;
      q_in = q;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en   = 1'b0;
      q_in = 2'd0;
      clr  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      // clr is high from time 0; check on each of the two reset cycles.
      en   = 1'b1;
      q_in = 2'd2;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total++;
         if ({wrap_cnt, wrap_pulse, carry, err} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_cycle%0d: got cnt=%0d pulse=%0b carry=%0b err=%0b want 0 0 0 0",
                     i, wrap_cnt, wrap_pulse, carry, err);
         end
      end
      clr = 1'b0;
      // Build up nonzero state, then assert clr mid-cycle: outputs clear at once.
      en = 1'b1;
      drive(1'b1, 2'd0);
      drive(1'b1, 2'd1);
      drive(1'b1, 2'd2);
      drive(1'b1, 2'd0);
      total++;
      if (wrap_pulse !== 1'b1 || wrap_cnt !== 2'd1) begin
         bad++;
         $display("FAIL reset_prewrap: got cnt=%0d pulse=%0b want 1 1", wrap_cnt, wrap_pulse);
      end
      #2 clr = 1'b1;
      #1;
      total++;
      if ({wrap_cnt, wrap_pulse, carry, err} !== 5'b00000) begin
         bad++;
         $display("FAIL reset_async: got cnt=%0d pulse=%0b carry=%0b err=%0b want 0 0 0 0",
                  wrap_cnt, wrap_pulse, carry, err);
      end
      @(posedge clk);
      #1;
      clr = 1'b0;
      // prev_q was 0 before reset; use q=0 first so a stale prev_q of 2 cannot fake a wrap.
      drive(1'b1, 2'd0);
      total++;
      if (wrap_pulse !== 1'b0 || wrap_cnt !== 2'd0 || err !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_sample: got cnt=%0d pulse=%0b err=%0b want 0 0 0",
                  wrap_cnt, wrap_pulse, err);
      end
   endtask

   task automatic test_wrap_basic();
      logic [1:0] qv [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
      logic       pv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0] cv [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, qv[i]);
         total++;
         if (wrap_pulse !== pv[i] || wrap_cnt !== cv[i] || carry !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL wrap_basic[%0d]: got pulse=%0b cnt=%0d carry=%0b err=%0b want %0b %0d 0 0",
                     i, wrap_pulse, wrap_cnt, carry, err, pv[i], cv[i]);
         end
      end
   endtask

   task automatic test_carry();
      logic [1:0] exp_cnt;
      logic       exp_pulse;
      logic       exp_carry;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 2'(i % 3));
         exp_pulse = (i == 3) || (i == 6) || (i == 9) || (i == 12);
         exp_carry = (i == 12);
         exp_cnt   = (i < 3) ? 2'd0 : (i < 6) ? 2'd1 : (i < 9) ? 2'd2 : (i < 12) ? 2'd3 : 2'd0;
         total++;
         if (wrap_pulse !== exp_pulse || carry !== exp_carry || wrap_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL carry[%0d]: got pulse=%0b carry=%0b cnt=%0d want %0b %0b %0d",
                     i, wrap_pulse, carry, wrap_cnt, exp_pulse, exp_carry, exp_cnt);
         end
      end
   endtask

   // Entry state: prev_q=1, wrap_cnt=0.
   task automatic test_upstream_clear();
      logic [1:0] qv [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
      logic       pv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0] cv [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, qv[i]);
         total++;
         if (wrap_pulse !== pv[i] || wrap_cnt !== cv[i] || carry !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL upstream_clear[%0d]: got pulse=%0b cnt=%0d carry=%0b err=%0b want %0b %0d 0 0",
                     i, wrap_pulse, wrap_cnt, carry, err, pv[i], cv[i]);
         end
      end
   endtask

   // Entry state: prev_q=0, wrap_cnt=1, wrap_pulse=1.
   task automatic test_enable_hold();
      logic       ev [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [1:0] qv [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
      for (int i = 0; i < 5; i++) begin
         drive(ev[i], qv[i]);
         total++;
         if (wrap_pulse !== 1'b0 || wrap_cnt !== 2'd1 || carry !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL enable_hold[%0d]: got pulse=%0b cnt=%0d carry=%0b err=%0b want 0 1 0 0",
                     i, wrap_pulse, wrap_cnt, carry, err);
         end
      end
      // prev_q froze at 2, so 2 -> 1 is no wrap but is an illegal step.
      drive(1'b1, 2'd1);
      total++;
      if (wrap_pulse !== 1'b0 || wrap_cnt !== 2'd1 || err !== CHK) begin
         bad++;
         $display("FAIL enable_resume: got pulse=%0b cnt=%0d err=%0b want 0 1 %0b",
                  wrap_pulse, wrap_cnt, err, CHK);
      end
   endtask

   task automatic test_err();
      do_reset();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL err_cleared: got err=%0b want 0", err);
      end
      drive(1'b1, 2'd0);
      drive(1'b1, 2'd1);
      drive(1'b1, 2'd3);   // out of range
      total++;
      if (err !== CHK || wrap_pulse !== 1'b0) begin
         bad++;
         $display("FAIL err_range: got err=%0b pulse=%0b want %0b 0", err, wrap_pulse, CHK);
      end
      drive(1'b1, 2'd0);   // prev_q=3 captured, so this is not a wrap
      total++;
      if (err !== CHK || wrap_pulse !== 1'b0 || wrap_cnt !== 2'd0) begin
         bad++;
         $display("FAIL err_sticky: got err=%0b pulse=%0b cnt=%0d want %0b 0 0",
                  err, wrap_pulse, wrap_cnt, CHK);
      end
      do_reset();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL err_reclear: got err=%0b want 0", err);
      end
      drive(1'b1, 2'd0);
      drive(1'b1, 2'd2);   // skip 0 -> 2
      total++;
      if (err !== CHK) begin
         bad++;
         $display("FAIL err_skip: got err=%0b want %0b", err, CHK);
      end
      drive(1'b1, 2'd0);   // wrap still detected with err set
      total++;
      if (err !== CHK || wrap_pulse !== 1'b1 || wrap_cnt !== 2'd1) begin
         bad++;
         $display("FAIL err_wrap: got err=%0b pulse=%0b cnt=%0d want %0b 1 1",
                  err, wrap_pulse, wrap_cnt, CHK);
      end
   endtask

   initial begin
      clr  = 1'b1;
      en   = 1'b0;
      q_in = 2'd0;
      test_reset();
      test_wrap_basic();
      test_carry();
      test_upstream_clear();
      test_enable_hold();
      test_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
